sram_req_arbiter: RTL and testbench



---
 rtl/sram_req_arbiter_pkg.sv | 22 ++
 rtl/sram_req_arbiter_id_fifo.sv | 63 ++++++
 rtl/sram_req_arbiter.sv | 173 +++++++++++++++++
 tb/tb_sram_req_arbiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_req_arbiter_pkg.sv
// Shared definitions for the SRAM-like request arbiter: master IDs, the
// lock-owner state encoding and the width of one packed request bus.
`ifndef SRAM_REQ_ARBITER_PKG_SV
`define SRAM_REQ_ARBITER_PKG_SV

// req + wr + wen[3:0] + addr[31:0] + wdata[31:0]
`define SRAM_REQ_BUS_W 70

package sram_req_arbiter_pkg;

    localparam logic MST_INST = 1'b0;
    localparam logic MST_DATA = 1'b1;

    typedef enum logic [1:0] {
        LOCK_FREE = 2'd0,
        LOCK_INST = 2'd1,
        LOCK_DATA = 2'd2
    } lock_state_t;

endpackage

`endif

// File: rtl/sram_req_arbiter_id_fifo.sv
// In-order FIFO of request owner IDs. Pointers wrap naturally because DEPTH
// is a power of two; push when full and pop when empty are ignored.
module sram_req_arbiter_id_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];
    assign count   = count_q;

    // Storage has no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers and occupancy; simultaneous push and pop leave count unchanged.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/sram_req_arbiter.sv
// Shares one SRAM-like port between instruction fetch (M0) and data (M1).
// Grant is combinational from registered lock/starve state, so the request
// path adds no latency; responses are steered by an in-order owner FIFO.
//
// state     | meaning
// LOCK_FREE | no request stalled; priority logic picks the grant
// LOCK_INST | inst request presented but not yet accepted; grant held on inst
// LOCK_DATA | data request presented but not yet accepted; grant held on data
module sram_req_arbiter
    import sram_req_arbiter_pkg::*;
#(
    parameter int OUTSTANDING  = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                          clk,
    input  logic                          resetn,

    input  logic                          inst_req,
    input  logic                          inst_wr,
    input  logic [3:0]                    inst_wen,
    input  logic [31:0]                   inst_addr,
    input  logic [31:0]                   inst_wdata,
    output logic                          inst_addr_ok,
    output logic                          inst_data_ok,
    output logic [31:0]                   inst_rdata,

    input  logic                          data_req,
    input  logic                          data_wr,
    input  logic [3:0]                    data_wen,
    input  logic [31:0]                   data_addr,
    input  logic [31:0]                   data_wdata,
    output logic                          data_addr_ok,
    output logic                          data_data_ok,
    output logic [31:0]                   data_rdata,

    output logic                          mem_req,
    output logic                          mem_wr,
    output logic [3:0]                    mem_wen,
    output logic [31:0]                   mem_addr,
    output logic [31:0]                   mem_wdata,
    input  logic                          mem_addr_ok,
    input  logic                          mem_data_ok,
    input  logic [31:0]                   mem_rdata,

    output logic [$clog2(OUTSTANDING):0]  outstanding_cnt,
    output logic                          resp_err
);

    // Down-counter of data grants still allowed before inst is forced.
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [SC_W-1:0] STARVE_LOAD = SC_W'(STARVE_LIMIT);

    lock_state_t               lock_q;
    lock_state_t               lock_d;
    logic [SC_W-1:0]           starve_left_q;
    logic                      gnt_vld;
    logic                      gnt_id;
    logic [`SRAM_REQ_BUS_W-1:0] inst_bus;
    logic [`SRAM_REQ_BUS_W-1:0] data_bus;
    logic [`SRAM_REQ_BUS_W-1:0] gnt_bus;
    logic                      hs;
    logic                      inst_hs;
    logic                      data_hs;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic [0:0]                fifo_din;
    logic [0:0]                fifo_dout;
    logic                      fifo_full;
    logic                      fifo_empty;

    // Grant selection: lock owner, else blocked when full, else starve
    // override, else data before inst. Nothing is granted while in reset.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = MST_DATA;
        if (resetn) begin
            if (lock_q == LOCK_INST) begin
                gnt_vld = 1'b1;
                gnt_id  = MST_INST;
            end else if (lock_q == LOCK_DATA) begin
                gnt_vld = 1'b1;
                gnt_id  = MST_DATA;
            end else if (fifo_full) begin
                gnt_vld = 1'b0;
            end else if (starve_left_q == '0 && inst_req) begin
                gnt_vld = 1'b1;
                gnt_id  = MST_INST;
            end else if (data_req) begin
                gnt_vld = 1'b1;
                gnt_id  = MST_DATA;
            end else if (inst_req) begin
                gnt_vld = 1'b1;
                gnt_id  = MST_INST;
            end
        end
    end

    assign inst_bus = {inst_req, inst_wr, inst_wen, inst_addr, inst_wdata};
    assign data_bus = {data_req, data_wr, data_wen, data_addr, data_wdata};
    assign gnt_bus  = !gnt_vld ? '0 : ((gnt_id == MST_DATA) ? data_bus : inst_bus);
    assign {mem_req, mem_wr, mem_wen, mem_addr, mem_wdata} = gnt_bus;

    assign hs           = mem_req && mem_addr_ok;
    assign inst_hs      = hs && (gnt_id == MST_INST);
    assign data_hs      = hs && (gnt_id == MST_DATA);
    assign inst_addr_ok = inst_hs;
    assign data_addr_ok = data_hs;

    // Lock state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lock_q <= LOCK_FREE;
        end else begin
            lock_q <= lock_d;
        end
    end

    // Hold the grant on a presented-but-unaccepted request; release on accept.
    always_comb begin
        lock_d = lock_q;
        if (hs) begin
            lock_d = LOCK_FREE;
        end else if (mem_req) begin
            lock_d = (gnt_id == MST_INST) ? LOCK_INST : LOCK_DATA;
        end
    end

    // Starve budget: reload whenever inst is idle or served, spend one per
    // data grant that inst had to wait behind, stop at zero.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            starve_left_q <= STARVE_LOAD;
        end else if (!inst_req || inst_hs) begin
            starve_left_q <= STARVE_LOAD;
        end else if (data_hs && starve_left_q != '0) begin
            starve_left_q <= starve_left_q - SC_W'(1);
        end
    end

    assign fifo_push = hs && !fifo_full;
    assign fifo_pop  = mem_data_ok && !fifo_empty;
    assign fifo_din  = gnt_id;

    sram_req_arbiter_id_fifo #(
        .DEPTH (OUTSTANDING),
        .WIDTH (1)
    ) u_id_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .din    (fifo_din),
        .dout   (fifo_dout),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .count  (outstanding_cnt)
    );

    assign inst_data_ok = fifo_pop && (fifo_dout[0] == MST_INST);
    assign data_data_ok = fifo_pop && (fifo_dout[0] == MST_DATA);
    assign inst_rdata   = mem_rdata;
    assign data_rdata   = mem_rdata;

    // Sticky flag for a response that has no outstanding request to match.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            resp_err <= 1'b0;
        end else if (mem_data_ok && fifo_empty) begin
            resp_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_sram_req_arbiter.sv
// Directed bench for sram_req_arbiter plus a short randomized scoreboard run.
module tb_sram_req_arbiter;

    logic        clk;
    logic        resetn;
    logic        inst_req, inst_wr;
    logic [3:0]  inst_wen;
    logic [31:0] inst_addr, inst_wdata;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        data_req, data_wr;
    logic [3:0]  data_wen;
    logic [31:0] data_addr, data_wdata;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        mem_req, mem_wr;
    logic [3:0]  mem_wen;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_addr_ok, mem_data_ok;
    logic [31:0] mem_rdata;
    logic [2:0]  outstanding_cnt;
    logic        resp_err;

    int n_tests = 0;
    int n_fail  = 0;

    sram_req_arbiter #(.OUTSTANDING(4), .STARVE_LIMIT(8)) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_req        (inst_req),
        .inst_wr         (inst_wr),
        .inst_wen        (inst_wen),
        .inst_addr       (inst_addr),
        .inst_wdata      (inst_wdata),
        .inst_addr_ok    (inst_addr_ok),
        .inst_data_ok    (inst_data_ok),
        .inst_rdata      (inst_rdata),
        .data_req        (data_req),
        .data_wr         (data_wr),
        .data_wen        (data_wen),
        .data_addr       (data_addr),
        .data_wdata      (data_wdata),
        .data_addr_ok    (data_addr_ok),
        .data_data_ok    (data_data_ok),
        .data_rdata      (data_rdata),
        .mem_req         (mem_req),
        .mem_wr          (mem_wr),
        .mem_wen         (mem_wen),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_addr_ok     (mem_addr_ok),
        .mem_data_ok     (mem_data_ok),
        .mem_rdata       (mem_rdata),
        .outstanding_cnt (outstanding_cnt),
        .resp_err        (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge, checks follow 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic idle();
        inst_req = 0; inst_wr = 0; inst_wen = 0; inst_addr = 0; inst_wdata = 0;
        data_req = 0; data_wr = 0; data_wen = 0; data_addr = 0; data_wdata = 0;
        mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = 0;
    endtask

    initial begin
        bit sb[$];
        bit head;
        bit i_acc, d_acc;
        int accepted;
        int cyc;

        resetn = 0;
        idle();
        inst_req = 1; inst_addr = 32'h1000;
        #1;
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_inst_aok", 32'(inst_addr_ok), 0);
        chk("rst_cnt", 32'(outstanding_cnt), 0);
        chk("rst_resp_err", 32'(resp_err), 0);
        tick();
        idle();
        tick();
        resetn = 1;
        tick();

        // Both request: data first, then inst; responses return in order.
        inst_req = 1; inst_addr = 32'h1000; inst_wen = 4'h3; inst_wdata = 32'h11;
        data_req = 1; data_addr = 32'h2000; data_wr = 1; data_wen = 4'hC; data_wdata = 32'h22;
        mem_addr_ok = 1;
        #1;
        chk("s1_mem_addr_d", mem_addr, 32'h2000);
        chk("s1_mem_wr_d", 32'(mem_wr), 1);
        chk("s1_mem_wen_d", 32'(mem_wen), 32'hC);
        chk("s1_data_aok", 32'(data_addr_ok), 1);
        chk("s1_inst_aok0", 32'(inst_addr_ok), 0);
        tick();
        data_req = 0; data_wr = 0;
        #1;
        chk("s1_mem_addr_i", mem_addr, 32'h1000);
        chk("s1_mem_wen_i", 32'(mem_wen), 32'h3);
        chk("s1_mem_wdata_i", mem_wdata, 32'h11);
        chk("s1_inst_aok", 32'(inst_addr_ok), 1);
        chk("s1_data_aok0", 32'(data_addr_ok), 0);
        chk("s1_cnt1", 32'(outstanding_cnt), 1);
        tick();
        inst_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'hAAAA;
        #1;
        chk("s1_cnt2", 32'(outstanding_cnt), 2);
        chk("s1_mem_req_idle", 32'(mem_req), 0);
        chk("s1_data_dok", 32'(data_data_ok), 1);
        chk("s1_inst_dok0", 32'(inst_data_ok), 0);
        chk("s1_data_rdata", data_rdata, 32'hAAAA);
        tick();
        mem_rdata = 32'hBBBB;
        #1;
        chk("s1_inst_dok", 32'(inst_data_ok), 1);
        chk("s1_data_dok0", 32'(data_data_ok), 0);
        chk("s1_inst_rdata", inst_rdata, 32'hBBBB);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s1_cnt0", 32'(outstanding_cnt), 0);

        // Lock: inst stalled by mem_addr_ok=0 keeps the port when data arrives.
        inst_req = 1; inst_addr = 32'h1000;
        #1;
        chk("s2_addr_c0", mem_addr, 32'h1000);
        chk("s2_inst_aok_c0", 32'(inst_addr_ok), 0);
        tick(); #1;
        chk("s2_addr_c1", mem_addr, 32'h1000);
        tick(); #1;
        chk("s2_addr_c2", mem_addr, 32'h1000);
        tick();
        data_req = 1; data_addr = 32'h2000;
        #1;
        chk("s2_addr_locked", mem_addr, 32'h1000);
        chk("s2_data_aok_locked", 32'(data_addr_ok), 0);
        tick();
        mem_addr_ok = 1;
        #1;
        chk("s2_addr_accept", mem_addr, 32'h1000);
        chk("s2_inst_aok", 32'(inst_addr_ok), 1);
        chk("s2_data_aok0", 32'(data_addr_ok), 0);
        tick();
        inst_req = 0;
        #1;
        chk("s2_addr_data", mem_addr, 32'h2000);
        chk("s2_data_aok", 32'(data_addr_ok), 1);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        chk("s2_cnt2", 32'(outstanding_cnt), 2);
        chk("s2_inst_dok", 32'(inst_data_ok), 1);
        tick(); #1;
        chk("s2_data_dok", 32'(data_data_ok), 1);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s2_cnt0", 32'(outstanding_cnt), 0);

        // Full FIFO blocks the grant; one response frees a slot for next cycle.
        data_req = 1; data_addr = 32'h3000; mem_addr_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s3_fill_aok", 32'(data_addr_ok), 1);
            tick();
        end
        mem_data_ok = 1;
        #1;
        chk("s3_full_cnt", 32'(outstanding_cnt), 4);
        chk("s3_full_mem_req", 32'(mem_req), 0);
        chk("s3_full_mem_addr", mem_addr, 0);
        chk("s3_full_data_aok", 32'(data_addr_ok), 0);
        chk("s3_full_inst_aok", 32'(inst_addr_ok), 0);
        chk("s3_full_dok", 32'(data_data_ok), 1);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s3_cnt3", 32'(outstanding_cnt), 3);
        chk("s3_reaccept", 32'(data_addr_ok), 1);
        tick();
        data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("s3_drain_dok", 32'(data_data_ok), 1);
            tick();
        end
        mem_data_ok = 0;
        #1;
        chk("s3_cnt0", 32'(outstanding_cnt), 0);

        // Starvation: 8 data grants, 1 forced inst grant, then data again.
        inst_req = 1; inst_addr = 32'h1000;
        data_req = 1; data_addr = 32'h2000;
        mem_addr_ok = 1;
        for (int i = 0; i < 10; i++) begin
            mem_data_ok = (i != 0);
            #1;
            chk("s4_data_aok", 32'(data_addr_ok), 32'(i != 8));
            chk("s4_inst_aok", 32'(inst_addr_ok), 32'(i == 8));
            chk("s4_cnt", 32'(outstanding_cnt), (i == 0) ? 0 : 1);
            if (i > 0) begin
                chk("s4_inst_dok", 32'(inst_data_ok), 32'(i == 9));
                chk("s4_data_dok", 32'(data_data_ok), 32'(i != 9));
            end
            tick();
        end
        inst_req = 0; data_req = 0; mem_addr_ok = 0; mem_data_ok = 1;
        #1;
        chk("s4_last_dok", 32'(data_data_ok), 1);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s4_cnt0", 32'(outstanding_cnt), 0);

        // Same-cycle push and pop at count 2.
        data_req = 1; data_addr = 32'h5000; mem_addr_ok = 1;
        tick();
        tick();
        mem_data_ok = 1;
        #1;
        chk("s5_cnt_pre", 32'(outstanding_cnt), 2);
        chk("s5_aok", 32'(data_addr_ok), 1);
        chk("s5_dok", 32'(data_data_ok), 1);
        tick();
        data_req = 0; mem_addr_ok = 0;
        #1;
        chk("s5_cnt_same", 32'(outstanding_cnt), 2);
        tick(); #1;
        chk("s5_cnt1", 32'(outstanding_cnt), 1);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s5_cnt0", 32'(outstanding_cnt), 0);

        // Random interleaving against an in-order owner scoreboard.
        accepted = 0;
        cyc = 0;
        while ((accepted < 20 || sb.size() != 0) && cyc < 500) begin
            if (!inst_req && accepted < 20 && $urandom_range(0, 1) == 1) begin
                inst_req = 1; inst_addr = $urandom;
            end
            if (!data_req && accepted < 20 && $urandom_range(0, 1) == 1) begin
                data_req = 1; data_addr = $urandom;
            end
            mem_addr_ok = ($urandom_range(0, 1) == 1);
            mem_data_ok = (sb.size() != 0) && ($urandom_range(0, 1) == 1);
            mem_rdata = $urandom;
            #1;
            chk("rnd_cnt", 32'(outstanding_cnt), sb.size());
            if (mem_data_ok) begin
                head = sb.pop_front();
                chk("rnd_inst_dok", 32'(inst_data_ok), 32'(head == 1'b0));
                chk("rnd_data_dok", 32'(data_data_ok), 32'(head == 1'b1));
                chk("rnd_rdata", head ? data_rdata : inst_rdata, mem_rdata);
            end else begin
                chk("rnd_no_dok", 32'({inst_data_ok, data_data_ok}), 0);
            end
            chk("rnd_aok_legal",
                32'((inst_addr_ok && !(inst_req && mem_addr_ok)) ||
                    (data_addr_ok && !(data_req && mem_addr_ok)) ||
                    (inst_addr_ok && data_addr_ok)), 0);
            i_acc = inst_addr_ok;
            d_acc = data_addr_ok;
            if (i_acc) begin sb.push_back(1'b0); accepted++; end
            if (d_acc) begin sb.push_back(1'b1); accepted++; end
            tick();
            if (i_acc) inst_req = 0;
            if (d_acc) data_req = 0;
            cyc++;
        end
        chk("rnd_completed", 32'(accepted >= 20 && sb.size() == 0), 1);
        idle();
        #1;
        chk("rnd_cnt0", 32'(outstanding_cnt), 0);
        tick();

        // Response with nothing outstanding is dropped and flagged stickily.
        mem_data_ok = 1;
        #1;
        chk("s6_empty_inst_dok", 32'(inst_data_ok), 0);
        chk("s6_empty_data_dok", 32'(data_data_ok), 0);
        chk("s6_err_pre", 32'(resp_err), 0);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s6_err_set", 32'(resp_err), 1);
        chk("s6_err_cnt", 32'(outstanding_cnt), 0);
        tick(); #1;
        chk("s6_err_sticky", 32'(resp_err), 1);

        // Asynchronous reset in the middle of a burst.
        data_req = 1; data_addr = 32'h4000; mem_addr_ok = 1;
        tick();
        tick();
        #1;
        chk("s7_cnt_pre", 32'(outstanding_cnt), 2);
        mem_data_ok = 1;
        resetn = 0;
        #1;
        chk("s7_mem_req", 32'(mem_req), 0);
        chk("s7_mem_addr", mem_addr, 0);
        chk("s7_data_aok", 32'(data_addr_ok), 0);
        chk("s7_inst_aok", 32'(inst_addr_ok), 0);
        chk("s7_data_dok", 32'(data_data_ok), 0);
        chk("s7_inst_dok", 32'(inst_data_ok), 0);
        chk("s7_cnt", 32'(outstanding_cnt), 0);
        chk("s7_err_clr", 32'(resp_err), 0);
        idle();
        tick();
        resetn = 1;
        mem_data_ok = 1;
        #1;
        chk("s7_post_data_dok", 32'(data_data_ok), 0);
        chk("s7_post_inst_dok", 32'(inst_data_ok), 0);
        tick();
        mem_data_ok = 0;
        #1;
        chk("s7_post_err", 32'(resp_err), 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
